// File: rtl/sram_controller.sv
// 32-bit MEM-stage data port to 16-bit asynchronous SRAM bridge.
// Each word access is split into a low then a high half-word access while ready is held low.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [12:0] unused_off_hi;
  logic [1:0]  unused_off_lo;
  logic [16:0] req_word;
  logic        last_cycle;
  logic        dq_oe;
  logic [15:0] dq_out;

  // Modular offset from the SRAM window base; byte-in-word bits are dropped.
  assign {unused_off_hi, req_word, unused_off_lo} = address - BASE_ADDR;

  assign last_cycle = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (rd_en || wr_en) begin
          state_d = S_LO;
          cnt_d   = '0;
          word_d  = req_word;
          wdata_d = write_data;
          is_wr_d = wr_en;
        end
      end
      S_LO: begin
        if (last_cycle) begin
          state_d = S_HI;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: begin
        if (last_cycle) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins depend only on registered state so request inputs never glitch them.
  assign dq_oe     = is_wr_q && ((state_q == S_LO) || (state_q == S_HI));
  assign dq_out    = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign SRAM_WE_N = ~(dq_oe && !last_cycle);
  assign SRAM_ADDR = {word_q, (state_q == S_HI)};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign read_data = rdata_q;
  assign ready     = (state_q == S_IDLE) ? ~(rd_en | wr_en) : (state_q == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural SRAM and a read-result scoreboard.
module tb_sram_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus only while the bench runs a load.
  logic [15:0] mem [0:255];
  logic        rd_drive = 1'b0;
  assign SRAM_DQ = rd_drive ? mem[SRAM_ADDR[7:0]] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access starting in an IDLE cycle; returns at the negedge of its DONE cycle.
  task automatic op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] exp_rd, input bit drop, input bit chk_we);
    int lows;
    bit done;
    logic [17:0] hw;
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; write_data = d;
    rd_drive = r & ~w;
    if (r && !w) exp_q.push_back(exp_rd);
    #1 chk("ready_cycle0", {31'd0, ready}, 32'd0);
    hw = 18'(((a - 32'd1024) >> 2) << 1);
    lows = 1;
    done = 1'b0;
    for (int c = 1; c < 20 && !done; c++) begin
      @(negedge clk);
      if (chk_we && c <= 4) begin
        chk($sformatf("we_n_c%0d", c), {31'd0, SRAM_WE_N}, (c % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("addr_c%0d", c), {14'd0, SRAM_ADDR}, {14'd0, hw + ((c > 2) ? 18'd1 : 18'd0)});
      end
      if (ready) done = 1'b1;
      else lows++;
    end
    chk("ready_low_cycles", 32'(lows), 32'd5);
    if (r && !w) begin
      last_rd = exp_q.pop_front();
      chk("read_data", read_data, last_rd);
    end else begin
      chk("read_data_kept", read_data, last_rd);
    end
    if (drop) begin
      wr_en = 1'b0; rd_en = 1'b0; rd_drive = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;

    op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, '0, 1'b1, 1'b1);
    chk("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    chk("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    op(1'b0, 1'b1, 32'd1024, '0, 32'hDEADBEEF, 1'b1, 1'b0);

    op(1'b1, 1'b0, 32'd1028, 32'h12345678, '0, 1'b1, 1'b1);
    op(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, '0, 1'b1, 1'b0);
    chk("mem2", {16'd0, mem[2]}, 32'h00005678);
    chk("mem3", {16'd0, mem[3]}, 32'h00001234);
    chk("mem4", {16'd0, mem[4]}, 32'h0000F00D);
    chk("mem5", {16'd0, mem[5]}, 32'h0000CAFE);
    op(1'b0, 1'b1, 32'd1028, '0, 32'h12345678, 1'b1, 1'b0);
    op(1'b0, 1'b1, 32'd1032, '0, 32'hCAFEF00D, 1'b1, 1'b0);

    // Both enables: performs a write, read_data must not move.
    op(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, '0, 1'b1, 1'b0);
    chk("simul_mem0", {16'd0, mem[0]}, 32'h0000A5A5);
    chk("simul_mem1", {16'd0, mem[1]}, 32'h0000A5A5);

    op(1'b0, 1'b1, 32'd1028, '0, 32'h12345678, 1'b0, 1'b0);
    op(1'b1, 1'b0, 32'd1036, 32'h0BADCAFE, '0, 1'b0, 1'b1);
    op(1'b0, 1'b1, 32'd1032, '0, 32'hCAFEF00D, 1'b1, 1'b0);
    @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("b2b_mem6", {16'd0, mem[6]}, 32'h0000CAFE);
    chk("b2b_mem7", {16'd0, mem[7]}, 32'h00000BAD);
    op(1'b0, 1'b1, 32'd1036, '0, 32'h0BADCAFE, 1'b1, 1'b0);

    // Reset in cycle 3 of a write: low half already stored, high half not.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h11112222;
    repeat (3) @(negedge clk);
    chk("mid_we_n_low", {31'd0, SRAM_WE_N}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("mid_rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("mid_rst_read_data", read_data, 32'd0);
    chk("mid_rst_ready_req", {31'd0, ready}, 32'd0);
    wr_en = 1'b0;
    #1 chk("mid_rst_ready_idle", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    op(1'b0, 1'b1, 32'd1024, '0, 32'hA5A52222, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
